cpu_debug_mem_arbiter: RTL and testbench
========================================

Name: cpu_debug_mem_arbiter

Overview:
Shares the Nios II on-chip debug memory (single-port, 1-cycle-read-latency OCI RAM) between two requesters. The first is the CPU's Avalon debug-memory slave. The second is the JTAG debug path: the jdo word plus the take_action/take_no_action ocimem strobes produced by the debug slave's sysclk half. The block sequences the JTAG strobes into RAM accesses with address auto-increment, arbitrates them against Avalon accesses, and returns read data to each side.

Parameters:
ADDR_W, 8, word-address width of the debug RAM (256 x 32).
DATA_W, 32, RAM data width; fixed at 32 to match the jdo data field.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
av_address  in  ADDR_W  Avalon word address.
av_read  in  1  Avalon read request.
av_write  in  1  Avalon write request.
av_writedata  in  32  Avalon write data.
av_byteenable  in  4  Avalon byte enables.
av_readdata  out  32  Avalon read data.
av_waitrequest  out  1  Avalon stall.
jdo  in  38  JTAG data: [17+:ADDR_W] address, [35] read-on-load, [34:3] write data.
take_action_ocimem_a  in  1  JTAG load-address strobe.
take_no_action_ocimem_a  in  1  JTAG read-and-increment strobe.
take_action_ocimem_b  in  1  JTAG write-and-increment strobe.
jtag_rdata  out  32  JTAG read data (MonDReg source).
jtag_rdata_valid  out  1  one-cycle pulse when jtag_rdata updates.
jtag_overrun  out  1  sticky: a JTAG strobe arrived while a JTAG op was pending.
ram_addr  out  ADDR_W  RAM address.
ram_we  out  1  RAM write enable.
ram_be  out  4  RAM byte enables.
ram_wdata  out  32  RAM write data.
ram_rdata  in  32  RAM read data, valid 1 cycle after the read address.

Behaviour:
- Reset values: av_waitrequest=1, av_readdata=0, jtag_rdata=0, jtag_rdata_valid=0, jtag_overrun=0, ram_we=0, ram_addr=0, ram_be=0, ram_wdata=0. Internal state: jaddr=0, jtag_pend=0, last_grant=AV, state=IDLE.
- JTAG command capture (1 pending slot):
  - action_a: jaddr<=jdo addr field. If jdo[35]=1, queue a read at the new jaddr.
  - no_action_a: queue a read at jaddr.
  - action_b: queue a write of jdo[34:3] to jaddr, be=4'hF.
  - Simultaneous strobes: priority action_b > action_a > no_action_a; lower-priority strobes are dropped and set jtag_overrun.
  - A strobe arriving while jtag_pend=1 is dropped and sets jtag_overrun, which stays set until reset.
- FSM states:
  - IDLE: evaluate requests; on a grant, drive the RAM port that same cycle.
  - AV_RD: ram_rdata is captured into av_readdata; av_waitrequest=0 for that one cycle; next state IDLE.
  - J_RD: ram_rdata is captured into jtag_rdata; jtag_rdata_valid pulses; jaddr increments; jtag_pend clears; next state IDLE.
- Writes complete in the grant cycle and the FSM stays in IDLE.
  - Avalon write: av_waitrequest=0 in the grant cycle.
  - JTAG write: jaddr increments and jtag_pend clears in the grant cycle.
- Latency:
  - Avalon write: 1 cycle with no contention.
  - Avalon read: readdata valid and waitrequest low on cycle 2.
  - JTAG read: jtag_rdata_valid 2 cycles after the queue cycle.
- Arbitration: round-robin. With both requesting, the grant goes to the side not in last_grant, and last_grant updates on every grant. A single requester is granted immediately. No grant is issued from AV_RD or J_RD, so back-to-back reads sustain 1 access per 2 cycles.
- av_waitrequest is 1 whenever the Avalon request is not completing this cycle. av_read and av_write asserted together is illegal; write takes precedence.
- jaddr wraps from 2^ADDR_W-1 to 0.
- Reset mid-operation aborts any read in flight: no readdata and no valid pulse. The pending JTAG op is lost.

Optional Feature:
DBG_MEM_ARB_JTAG_PRIO_EN.
- Defined: a pending JTAG op always wins contention, and last_grant is ignored.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package cpu_debug_mem_arb_pkg holds:
  - FSM state enum (IDLE, AV_RD, J_RD) and grant enum (GNT_AV, GNT_JTAG).
  - jdo field constants: JDO_ADDR_LSB=17, JDO_RD_BIT=35, JDO_WDATA_MSB=34, JDO_WDATA_LSB=3.
- Sub-module cpu_debug_mem_rr_arb: 2-way round-robin grant with last_grant register and the priority-override input for the optional feature.

Test Plan:
- JTAG action_a with addr=0x10, jdo[35]=1, RAM[0x10]=0xDEADBEEF -> jtag_rdata=0xDEADBEEF, valid pulse at cycle+2, jaddr=0x11.
- JTAG action_b wdata=0x12345678 at jaddr=0xFF -> RAM[0xFF] written, jaddr wraps to 0x00.
- Avalon read and JTAG read requested in the same cycle with last_grant=AV -> JTAG granted first, Avalon readdata returns 2 cycles later, last_grant=AV after. With DBG_MEM_ARB_JTAG_PRIO_EN defined, JTAG still wins when last_grant=JTAG.
- Avalon write be=4'b0011 data=0xAABBCCDD addr=0x05 -> ram_we=1, ram_be=0011, av_waitrequest=0 in the same cycle.
- Second JTAG strobe 1 cycle after no_action_a while pending -> strobe dropped, jtag_overrun=1 and held.
- reset asserted during AV_RD -> av_waitrequest=1 and av_readdata=0 immediately; no valid completion.

Source files
------------

// File: rtl/cpu_debug_mem_arb_pkg.sv
// Shared types and jdo field positions for the Nios II debug-memory arbiter.
package cpu_debug_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AV_RD = 2'd1,
    J_RD  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_AV   = 1'b0,
    GNT_JTAG = 1'b1
  } grant_t;

  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RD_BIT    = 35;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/cpu_debug_mem_rr_arb.sv
// Two-way round-robin arbiter between the Avalon side and the JTAG side.
// jtag_prio forces the JTAG side to win any contention (used when the
// DBG_MEM_ARB_JTAG_PRIO_EN build option is enabled in the top).
module cpu_debug_mem_rr_arb
  import cpu_debug_mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_av,
  input  logic req_jtag,
  input  logic jtag_prio,
  output logic gnt_av,
  output logic gnt_jtag
);

  grant_t last_grant_r;

  // Grant decision: lone requester wins, contention goes to the side not served last.
  always_comb begin
    gnt_av   = 1'b0;
    gnt_jtag = 1'b0;
    if (req_av && req_jtag) begin
      if (jtag_prio || (last_grant_r == GNT_AV)) begin
        gnt_jtag = 1'b1;
      end else begin
        gnt_av = 1'b1;
      end
    end else if (req_av) begin
      gnt_av = 1'b1;
    end else if (req_jtag) begin
      gnt_jtag = 1'b1;
    end else begin
      gnt_av   = 1'b0;
      gnt_jtag = 1'b0;
    end
  end

  // Remember which side was served on every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= GNT_AV;
    end else if (gnt_jtag) begin
      last_grant_r <= GNT_JTAG;
    end else if (gnt_av) begin
      last_grant_r <= GNT_AV;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/cpu_debug_mem_arbiter.sv
// Shares the single-port OCI debug RAM between the CPU Avalon debug slave
// and the JTAG ocimem strobes. JTAG strobes are captured into a one-entry
// pending slot with address auto-increment; reads take two cycles (grant,
// then data return), writes complete in the grant cycle.
// Build option: DBG_MEM_ARB_JTAG_PRIO_EN makes a pending JTAG op always win
// contention instead of alternating round-robin.
module cpu_debug_mem_arbiter
  import cpu_debug_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_rdata_valid,
  output logic              jtag_overrun,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   jaddr_r;
  logic                jtag_pend_r;
  logic                jtag_is_wr_r;
  logic [DATA_W-1:0]   jtag_wdata_r;
  logic                jtag_overrun_r;
  logic [DATA_W-1:0]   av_rdata_r;
  logic [DATA_W-1:0]   jtag_rdata_r;

  logic                sel_b_s;
  logic                sel_a_s;
  logic                sel_n_s;
  logic                multi_strobe_s;
  logic                any_strobe_s;
  logic                overrun_evt_s;
  logic                queue_op_s;
  logic                jtag_done_s;
  logic                idle_s;
  logic                req_av_s;
  logic                req_jtag_s;
  logic                gnt_av_s;
  logic                gnt_jtag_s;
  logic                jtag_prio_s;
  logic                unused_jdo_s;

  assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

`ifdef DBG_MEM_ARB_JTAG_PRIO_EN
  assign jtag_prio_s = 1'b1;
`else
  assign jtag_prio_s = 1'b0;
`endif

  // Strobe priority decode and overrun detection (dropped or colliding strobes).
  always_comb begin
    sel_b_s        = take_action_ocimem_b;
    sel_a_s        = take_action_ocimem_a & ~take_action_ocimem_b;
    sel_n_s        = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    any_strobe_s   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    multi_strobe_s = (take_action_ocimem_b & take_action_ocimem_a) |
                     (take_action_ocimem_b & take_no_action_ocimem_a) |
                     (take_action_ocimem_a & take_no_action_ocimem_a);
    if (jtag_pend_r) begin
      overrun_evt_s = any_strobe_s;
      queue_op_s    = 1'b0;
    end else begin
      overrun_evt_s = multi_strobe_s;
      queue_op_s    = sel_b_s | sel_n_s | (sel_a_s & jdo[JDO_RD_BIT]);
    end
  end

  // Requests are only considered from IDLE and never while reset is held.
  assign idle_s     = (state_r == IDLE) & ~reset;
  assign req_av_s   = idle_s & (av_read | av_write);
  assign req_jtag_s = idle_s & jtag_pend_r;

  cpu_debug_mem_rr_arb u_rr_arb (
    .clk       (clk),
    .reset     (reset),
    .req_av    (req_av_s),
    .req_jtag  (req_jtag_s),
    .jtag_prio (jtag_prio_s),
    .gnt_av    (gnt_av_s),
    .gnt_jtag  (gnt_jtag_s)
  );

  // FSM next state and RAM port drive; the RAM port is driven in the grant cycle.
  always_comb begin
    state_nxt_s    = state_r;
    ram_addr       = {ADDR_W{1'b0}};
    ram_we         = 1'b0;
    ram_be         = 4'h0;
    ram_wdata      = {DATA_W{1'b0}};
    av_waitrequest = 1'b1;
    jtag_done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (gnt_jtag_s) begin
          ram_addr = jaddr_r;
          if (jtag_is_wr_r) begin
            ram_we      = 1'b1;
            ram_be      = 4'hF;
            ram_wdata   = jtag_wdata_r;
            jtag_done_s = 1'b1;
          end else begin
            state_nxt_s = J_RD;
          end
        end else if (gnt_av_s) begin
          ram_addr = av_address;
          if (av_write) begin
            ram_we         = 1'b1;
            ram_be         = av_byteenable;
            ram_wdata      = av_writedata;
            av_waitrequest = 1'b0;
          end else begin
            state_nxt_s = AV_RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      AV_RD: begin
        av_waitrequest = 1'b0;
        state_nxt_s    = IDLE;
      end
      J_RD: begin
        jtag_done_s = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Read data is presented straight from the RAM in the completion cycle, then held.
  assign av_readdata      = (state_r == AV_RD) ? ram_rdata : av_rdata_r;
  assign jtag_rdata       = (state_r == J_RD)  ? ram_rdata : jtag_rdata_r;
  assign jtag_rdata_valid = (state_r == J_RD);
  assign jtag_overrun     = jtag_overrun_r;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // JTAG pending slot, auto-incrementing address and sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jaddr_r        <= {ADDR_W{1'b0}};
      jtag_pend_r    <= 1'b0;
      jtag_is_wr_r   <= 1'b0;
      jtag_wdata_r   <= {DATA_W{1'b0}};
      jtag_overrun_r <= 1'b0;
    end else begin
      jtag_overrun_r <= jtag_overrun_r | overrun_evt_s;
      if (jtag_done_s) begin
        jaddr_r     <= jaddr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        jtag_pend_r <= 1'b0;
      end else if (!jtag_pend_r && sel_a_s) begin
        jaddr_r     <= jdo[JDO_ADDR_LSB +: ADDR_W];
        jtag_pend_r <= queue_op_s;
      end else if (queue_op_s) begin
        jtag_pend_r <= 1'b1;
      end else begin
        jtag_pend_r <= jtag_pend_r;
      end
      if (queue_op_s) begin
        jtag_is_wr_r <= sel_b_s;
        jtag_wdata_r <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
      end else begin
        jtag_is_wr_r <= jtag_is_wr_r;
        jtag_wdata_r <= jtag_wdata_r;
      end
    end
  end

  // Hold the last read data returned to each side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      av_rdata_r   <= {DATA_W{1'b0}};
      jtag_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (state_r == AV_RD) begin
        av_rdata_r <= ram_rdata;
      end else begin
        av_rdata_r <= av_rdata_r;
      end
      if (state_r == J_RD) begin
        jtag_rdata_r <= ram_rdata;
      end else begin
        jtag_rdata_r <= jtag_rdata_r;
      end
    end
  end

endmodule

// File: tb/tb_cpu_debug_mem_arbiter.sv
// Directed self-checking bench for cpu_debug_mem_arbiter with a behavioural
// 256x32 single-port RAM (1-cycle read latency, byte-enabled writes).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_cpu_debug_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] jtag_rdata;
  logic        jtag_rdata_valid;
  logic        jtag_overrun;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:255];
  int pass_cnt = 0;
  int total_cnt = 0;

  cpu_debug_mem_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .jtag_rdata              (jtag_rdata),
    .jtag_rdata_valid        (jtag_rdata_valid),
    .jtag_overrun            (jtag_overrun),
    .ram_addr                (ram_addr),
    .ram_we                  (ram_we),
    .ram_be                  (ram_be),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural debug RAM.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes_off();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
    logic [37:0] v;
    v = 38'd0;
    v[24:17] = addr;
    v[35] = rd;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] wd);
    logic [37:0] v;
    v = 38'd0;
    v[34:3] = wd;
    return v;
  endfunction

  task automatic test_reset();
    #3;
    total_cnt++; if (av_waitrequest !== 1'b1) $display("FAIL rst_waitreq: got %b want 1", av_waitrequest); else pass_cnt++;
    total_cnt++; if (av_readdata !== 32'h0) $display("FAIL rst_av_readdata: got %h want 0", av_readdata); else pass_cnt++;
    total_cnt++; if (jtag_rdata !== 32'h0) $display("FAIL rst_jtag_rdata: got %h want 0", jtag_rdata); else pass_cnt++;
    total_cnt++; if ({jtag_rdata_valid, jtag_overrun, ram_we} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {jtag_rdata_valid, jtag_overrun, ram_we}); else pass_cnt++;
    total_cnt++; if ({ram_addr, ram_be, ram_wdata} !== 44'h0) $display("FAIL rst_ram_port: got %h want 0", {ram_addr, ram_be, ram_wdata}); else pass_cnt++;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_jtag_read();
    jdo = jdo_a(8'h10, 1'b1);
    take_action_ocimem_a = 1'b1;
    cyc();
    strobes_off();
    #1;
    total_cnt++; if (ram_addr !== 8'h10 || ram_we !== 1'b0) $display("FAIL jrd_grant: got addr %h we %b want 10 0", ram_addr, ram_we); else pass_cnt++;
    cyc();
    total_cnt++; if (jtag_rdata_valid !== 1'b1 || jtag_rdata !== 32'hDEADBEEF) $display("FAIL jrd_data: got v %b d %h want 1 deadbeef", jtag_rdata_valid, jtag_rdata); else pass_cnt++;
    cyc();
    total_cnt++; if (jtag_rdata_valid !== 1'b0 || jtag_rdata !== 32'hDEADBEEF) $display("FAIL jrd_hold: got v %b d %h want 0 deadbeef", jtag_rdata_valid, jtag_rdata); else pass_cnt++;
    take_no_action_ocimem_a = 1'b1;
    cyc();
    strobes_off();
    #1;
    total_cnt++; if (ram_addr !== 8'h11) $display("FAIL jrd_incr: got addr %h want 11", ram_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (jtag_rdata_valid !== 1'b1 || jtag_rdata !== 32'hA5A5A511) $display("FAIL jrd_next: got v %b d %h want 1 a5a5a511", jtag_rdata_valid, jtag_rdata); else pass_cnt++;
    cyc();
  endtask

  task automatic test_jtag_write_wrap();
    jdo = jdo_a(8'hFF, 1'b0);
    take_action_ocimem_a = 1'b1;
    cyc();
    strobes_off();
    jdo = jdo_b(32'h12345678);
    take_action_ocimem_b = 1'b1;
    #1;
    total_cnt++; if (ram_we !== 1'b0) $display("FAIL jwr_load_only: got we %b want 0", ram_we); else pass_cnt++;
    cyc();
    strobes_off();
    #1;
    total_cnt++; if (ram_we !== 1'b1 || ram_addr !== 8'hFF || ram_be !== 4'hF || ram_wdata !== 32'h12345678) $display("FAIL jwr_port: got we %b a %h be %h d %h want 1 ff f 12345678", ram_we, ram_addr, ram_be, ram_wdata); else pass_cnt++;
    cyc();
    total_cnt++; if (mem[255] !== 32'h12345678) $display("FAIL jwr_mem: got %h want 12345678", mem[255]); else pass_cnt++;
    take_no_action_ocimem_a = 1'b1;
    cyc();
    strobes_off();
    #1;
    total_cnt++; if (ram_addr !== 8'h00) $display("FAIL jwr_wrap: got addr %h want 00", ram_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (jtag_rdata !== 32'hA5A5A500) $display("FAIL jwr_wrap_rd: got %h want a5a5a500", jtag_rdata); else pass_cnt++;
    cyc();
  endtask

  task automatic test_av_write();
    av_address = 8'h05; av_writedata = 32'hAABBCCDD; av_byteenable = 4'b0011; av_write = 1'b1;
    #1;
    total_cnt++; if (ram_we !== 1'b1 || ram_be !== 4'b0011 || av_waitrequest !== 1'b0 || ram_addr !== 8'h05) $display("FAIL avwr_port: got we %b be %b wr %b a %h want 1 0011 0 05", ram_we, ram_be, av_waitrequest, ram_addr); else pass_cnt++;
    cyc();
    av_write = 1'b0;
    total_cnt++; if (mem[5] !== 32'hA5A5CCDD) $display("FAIL avwr_mem: got %h want a5a5ccdd", mem[5]); else pass_cnt++;
  endtask

  task automatic test_av_read();
    av_address = 8'h10; av_read = 1'b1;
    #1;
    total_cnt++; if (av_waitrequest !== 1'b1 || ram_addr !== 8'h10) $display("FAIL avrd_c1: got wr %b a %h want 1 10", av_waitrequest, ram_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'hDEADBEEF) $display("FAIL avrd_c2: got wr %b d %h want 0 deadbeef", av_waitrequest, av_readdata); else pass_cnt++;
    cyc();
    av_read = 1'b0;
    #1;
    total_cnt++; if (av_waitrequest !== 1'b1 || av_readdata !== 32'hDEADBEEF) $display("FAIL avrd_hold: got wr %b d %h want 1 deadbeef", av_waitrequest, av_readdata); else pass_cnt++;
  endtask

  task automatic test_contention();
    // last grant is Avalon: JTAG read (jaddr 01) goes first.
    take_no_action_ocimem_a = 1'b1;
    cyc();
    strobes_off();
    av_address = 8'h05; av_read = 1'b1;
    #1;
    total_cnt++; if (ram_addr !== 8'h01 || av_waitrequest !== 1'b1) $display("FAIL cont_jgrant: got a %h wr %b want 01 1", ram_addr, av_waitrequest); else pass_cnt++;
    cyc();
    total_cnt++; if (jtag_rdata_valid !== 1'b1 || jtag_rdata !== 32'hA5A5A501 || av_waitrequest !== 1'b1) $display("FAIL cont_jdata: got v %b d %h wr %b want 1 a5a5a501 1", jtag_rdata_valid, jtag_rdata, av_waitrequest); else pass_cnt++;
    cyc();
    total_cnt++; if (ram_addr !== 8'h05 || av_waitrequest !== 1'b1) $display("FAIL cont_avgrant: got a %h wr %b want 05 1", ram_addr, av_waitrequest); else pass_cnt++;
    cyc();
    total_cnt++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'hA5A5CCDD) $display("FAIL cont_avdata: got wr %b d %h want 0 a5a5ccdd", av_waitrequest, av_readdata); else pass_cnt++;
    cyc();
    av_read = 1'b0;
    // JTAG write at 02 makes JTAG the last grant, then contend again.
    jdo = jdo_b(32'h0BADF00D);
    take_action_ocimem_b = 1'b1;
    cyc();
    strobes_off();
    #1;
    total_cnt++; if (ram_we !== 1'b1 || ram_addr !== 8'h02) $display("FAIL cont_jwr: got we %b a %h want 1 02", ram_we, ram_addr); else pass_cnt++;
    cyc();
    take_no_action_ocimem_a = 1'b1;
    cyc();
    strobes_off();
    av_address = 8'h10; av_read = 1'b1;
    #1;
`ifdef DBG_MEM_ARB_JTAG_PRIO_EN
    total_cnt++; if (ram_addr !== 8'h03) $display("FAIL prio_grant: got a %h want 03", ram_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (jtag_rdata_valid !== 1'b1 || jtag_rdata !== 32'hA5A5A503) $display("FAIL prio_jdata: got v %b d %h want 1 a5a5a503", jtag_rdata_valid, jtag_rdata); else pass_cnt++;
    cyc();
    cyc();
    total_cnt++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'hDEADBEEF) $display("FAIL prio_avdata: got wr %b d %h want 0 deadbeef", av_waitrequest, av_readdata); else pass_cnt++;
    cyc();
    av_read = 1'b0;
`else
    total_cnt++; if (ram_addr !== 8'h10) $display("FAIL rr_grant: got a %h want 10", ram_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'hDEADBEEF) $display("FAIL rr_avdata: got wr %b d %h want 0 deadbeef", av_waitrequest, av_readdata); else pass_cnt++;
    cyc();
    av_read = 1'b0;
    #1;
    total_cnt++; if (ram_addr !== 8'h03) $display("FAIL rr_jgrant: got a %h want 03", ram_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (jtag_rdata_valid !== 1'b1 || jtag_rdata !== 32'hA5A5A503) $display("FAIL rr_jdata: got v %b d %h want 1 a5a5a503", jtag_rdata_valid, jtag_rdata); else pass_cnt++;
    cyc();
`endif
    total_cnt++; if (jtag_overrun !== 1'b0 || mem[2] !== 32'h0BADF00D) $display("FAIL cont_clean: got ovr %b mem2 %h want 0 0badf00d", jtag_overrun, mem[2]); else pass_cnt++;
  endtask

  task automatic test_overrun();
    take_no_action_ocimem_a = 1'b1;
    cyc();
    strobes_off();
    jdo = jdo_b(32'hFFFFFFFF);
    take_action_ocimem_b = 1'b1;
    #1;
    total_cnt++; if (jtag_overrun !== 1'b0 || ram_addr !== 8'h04) $display("FAIL ovr_pre: got ovr %b a %h want 0 04", jtag_overrun, ram_addr); else pass_cnt++;
    cyc();
    strobes_off();
    #1;
    total_cnt++; if (jtag_overrun !== 1'b1 || jtag_rdata !== 32'hA5A5A504) $display("FAIL ovr_set: got ovr %b d %h want 1 a5a5a504", jtag_overrun, jtag_rdata); else pass_cnt++;
    cyc();
    cyc();
    total_cnt++; if (jtag_overrun !== 1'b1 || ram_we !== 1'b0 || mem[5] !== 32'hA5A5CCDD) $display("FAIL ovr_hold: got ovr %b we %b mem5 %h want 1 0 a5a5ccdd", jtag_overrun, ram_we, mem[5]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    av_address = 8'h10; av_read = 1'b1;
    cyc();
    total_cnt++; if (av_waitrequest !== 1'b0) $display("FAIL rmid_avrd: got wr %b want 0", av_waitrequest); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (av_waitrequest !== 1'b1 || av_readdata !== 32'h0 || jtag_overrun !== 1'b0) $display("FAIL rmid_abort: got wr %b d %h ovr %b want 1 0 0", av_waitrequest, av_readdata, jtag_overrun); else pass_cnt++;
    av_read = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    total_cnt++; if (av_waitrequest !== 1'b1 || av_readdata !== 32'h0 || jtag_rdata_valid !== 1'b0) $display("FAIL rmid_after: got wr %b d %h v %b want 1 0 0", av_waitrequest, av_readdata, jtag_rdata_valid); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {24'hA5A5A5, i[7:0]};
    mem[16] = 32'hDEADBEEF;
    reset = 1'b1;
    av_address = 8'h00; av_read = 1'b0; av_write = 1'b0;
    av_writedata = 32'h0; av_byteenable = 4'h0;
    jdo = 38'd0;
    strobes_off();
    test_reset();
    test_jtag_read();
    test_jtag_write_wrap();
    test_av_write();
    test_av_read();
    test_contention();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
